// File: rtl/quiz_arbiter.sv
// quiz_arbiter: four-contestant buzz-in arbiter with per-second answer countdown and host scoring
// Define QUIZ_FOUL_DETECT_EN to penalise and flag buzzes made before the host arms the round.
module quiz_arbiter #(
  parameter int CLK_FREQ    = 12000000,
  parameter int ANSWER_TIME = 9,
  parameter int MAX_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_add_n,
  input  logic       key_sub_n,
  input  logic [3:0] btn_n,
  output logic [3:0] sel_n,
`ifdef QUIZ_FOUL_DETECT_EN
  output logic [3:0] foul_n,
`endif
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] score4,
  output logic [3:0] countdown,
  output logic       armed,
  output logic       timeout,
  output logic       beep
);
  localparam int CW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(CLK_FREQ - 1);
  localparam logic [3:0] T_LOAD = 4'(ANSWER_TIME);
  localparam logic [3:0] S_MAX = 4'(MAX_SCORE);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TMO} state_t;

  state_t        r_state, w_nxt;
  logic [6:0]    r_s1, r_s2, r_s3, r_ev;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cd, r_sel_n;
  logic [3:0]    r_score [4];
  logic [1:0]    r_win, w_win;
  logic          r_armed, r_timeout, r_beep;
  logic          w_start, w_add, w_sub, w_any, w_wrap, w_grant, w_enter;
  logic [3:0]    w_btn;

  // Synchronise, then register the falling-edge event so it is seen two edges after capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
      r_s3 <= '1;
      r_ev <= '0;
    end else begin
      r_s1 <= {key_start_n, key_add_n, key_sub_n, btn_n};
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_ev <= r_s3 & ~r_s2;
    end
  end

  assign {w_start, w_add, w_sub, w_btn} = r_ev;
  assign w_any   = |w_btn;
  assign w_win   = w_btn[0] ? 2'd0 : w_btn[1] ? 2'd1 : w_btn[2] ? 2'd2 : 2'd3;
  assign w_wrap  = r_cnt == TICK_MAX;
  assign w_grant = r_state == ARMED && w_any;
  assign w_enter = w_nxt == ARMED && r_state != ARMED;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_nxt;
  end

  // A buzz beats a simultaneous timeout
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_start ? ARMED : IDLE;
      ARMED:   w_nxt = w_any ? LOCKED : (w_wrap && r_cd == 4'd0) ? TMO : ARMED;
      LOCKED:  w_nxt = (w_add ^ w_sub) ? IDLE : LOCKED;
      default: w_nxt = w_start ? ARMED : TMO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_cd      <= 4'hf;
      r_sel_n   <= 4'hf;
      r_win     <= 2'd0;
      r_armed   <= 1'b0;
      r_timeout <= 1'b0;
      r_beep    <= 1'b0;
      for (int i = 0; i < 4; i++) r_score[i] <= 4'd0;
    end else begin
      r_cnt     <= (r_state == ARMED && w_nxt == ARMED && !w_wrap) ? r_cnt + 1'b1 : '0;
      r_cd      <= w_enter ? T_LOAD :
                   w_nxt == IDLE ? 4'hf :
                   w_nxt == TMO ? 4'h0 :
                   (w_nxt == ARMED && w_wrap) ? r_cd - 4'd1 : r_cd;
      r_sel_n   <= w_grant ? ~(4'b0001 << w_win) : w_nxt == LOCKED ? r_sel_n : 4'hf;
      r_win     <= w_grant ? w_win : r_win;
      r_armed   <= w_nxt == ARMED;
      r_timeout <= w_nxt == TMO;
      r_beep    <= r_state == ARMED && w_nxt != ARMED;
      for (int i = 0; i < 4; i++) begin
        if (r_state == LOCKED && r_win == 2'(i) && w_add && !w_sub && r_score[i] < S_MAX)
          r_score[i] <= r_score[i] + 4'd1;
        else if (r_state == LOCKED && r_win == 2'(i) && w_sub && !w_add && r_score[i] != 4'd0)
          r_score[i] <= r_score[i] - 4'd1;
`ifdef QUIZ_FOUL_DETECT_EN
        else if (r_state == IDLE && w_btn[i] && r_score[i] != 4'd0)
          r_score[i] <= r_score[i] - 4'd1;
`endif
      end
    end
  end

`ifdef QUIZ_FOUL_DETECT_EN
  logic [3:0] r_foul_n;

  always_ff @(posedge clk) begin
    if (!rst) r_foul_n <= 4'hf;
    else r_foul_n <= (w_start ? 4'hf : r_foul_n) & ~(r_state == IDLE ? w_btn : 4'h0);
  end

  assign foul_n = r_foul_n;
`endif

  assign sel_n     = r_sel_n;
  assign score1    = r_score[0];
  assign score2    = r_score[1];
  assign score3    = r_score[2];
  assign score4    = r_score[3];
  assign countdown = r_cd;
  assign armed     = r_armed;
  assign timeout   = r_timeout;
  assign beep      = r_beep;
endmodule

// File: doc/quiz_arbiter.md
Name: quiz_arbiter

Overview:
- Four-contestant buzz-in controller for the quiz score display.
- Arms on a host start key and grants the first contestant to buzz. Runs a per-second answer countdown and applies host add/subtract scoring to the granted contestant's score register.
- Drives active-low contestant selects and four 4-bit scores straight into the downstream score display mux, plus the countdown digit for a second segment display.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz; one countdown tick every CLK_FREQ cycles.
- ANSWER_TIME, 9, countdown start value in seconds, range 1..9.
- MAX_SCORE, 9, score saturation ceiling, range 1..14.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- key_start_n  input  1  host arm key, debounced, active-low level.
- key_add_n  input  1  host award key, debounced, active-low level.
- key_sub_n  input  1  host penalty key, debounced, active-low level.
- btn_n  input  4  contestant buzzers, bit i = contestant i+1, debounced, active-low.
- sel_n  output  4  active-low one-hot granted contestant; 4'b1111 = none.
- score1, score2, score3, score4  output  4 each  contestant scores, unsigned.
- countdown  output  4  remaining seconds; 4'b1111 = blank.
- armed  output  1  high while waiting for a buzz.
- timeout  output  1  high in TIMEOUT.
- beep  output  1  one-cycle pulse on grant and on timeout.

Behaviour:
- All key and button inputs pass through 2-flop synchronisers, then a falling-edge detector (press event = 1→0 transition). An input falling before edge N produces its event at cycle N+2. The resulting state/output update is registered at edge N+3.
- Reset values: state IDLE, sel_n 4'b1111, all scores 0, countdown 4'b1111, armed 0, timeout 0, beep 0, tick counter 0. Synchroniser flops reset to 1 (released).
- IDLE: countdown blank, sel_n 4'b1111.
  - start event → ARMED; countdown loads ANSWER_TIME; tick counter clears.
  - Buzzer events are ignored (see optional feature).
- ARMED: armed=1; tick counter counts 0..CLK_FREQ-1.
  - On wrap, countdown decrements.
  - Countdown at 0 together with a wrap → TIMEOUT, beep=1 for one cycle.
  - Any buzzer event → LOCKED: sel_n = ~onehot(winner), countdown frozen, beep=1 for one cycle.
  - Simultaneous buzzer events: fixed priority, lowest index wins (contestant 1 highest).
  - Buzzer event in the same cycle as the timeout condition: the buzzer wins (LOCKED).
  - start event in ARMED is ignored.
- LOCKED: all buzzer and start events ignored.
  - add event → winner score +1, saturating at MAX_SCORE; → IDLE.
  - sub event → winner score −1, saturating at 0; → IDLE.
  - add and sub events in the same cycle → both ignored, remain LOCKED.
  - On returning to IDLE, sel_n goes to 4'b1111 and countdown blanks in the same cycle the score updates.
- TIMEOUT: timeout=1, countdown shows 0, sel_n 4'b1111.
  - start event → ARMED (re-arm, countdown reload).
  - add/sub/buzzer events ignored.
- Scores change only in LOCKED (or via the optional foul rule). They are cleared only by rst.
- rst low at any edge, including mid-countdown or in LOCKED, returns everything to reset values on that edge.
- State encoding is implementer's choice. Outputs are registered, with no combinational input-to-output paths.

Optional Feature:
- Macro: QUIZ_FOUL_DETECT_EN.
- Defined:
  - A buzzer event in IDLE is a false start. That contestant's score is decremented, saturating at 0.
  - Output foul_n (4, active-low one-hot) latches the offender until the next start event or rst. Reset value 4'b1111.
  - Several simultaneous fouls are all penalised.
- Undefined:
  - Buzzer events in IDLE are ignored.
  - foul_n port is absent.

Test Plan:
- Bench CLK_FREQ=10, ANSWER_TIME=3. Reset, press start → armed=1 at edge +3, countdown 3, then 2/1/0 at 10-cycle intervals. Timeout=1 and one beep pulse 10 cycles after countdown reaches 0; sel_n stays 1111.
- Armed, btn_n 4'b1011 (contestant 3) → sel_n 4'b1011, beep one cycle, countdown frozen. Later presses of btn 1 are ignored.
- Armed, btn_n 4'b0110 in the same cycle (contestants 1 and 4) → sel_n 4'b1110. Then add → score1 0→1, state IDLE, sel_n 1111.
- Score saturation:
  - Contestant 2 awarded 10 times with MAX_SCORE=9 → score2 = 9.
  - Contestant 4 at 0 penalised with sub → score4 stays 0.
  - add+sub pressed together in LOCKED → no change, still LOCKED.
- Reset mid-operation:
  - rst low during ARMED with countdown 2 → next edge: countdown 1111, armed 0.
  - rst low while LOCKED with score3=5 → score3=0.
- With QUIZ_FOUL_DETECT_EN, contestant 2 at score 3 presses in IDLE → score2=2, foul_n 4'b1101. Next start event → foul_n 1111. Without the macro → score2 stays 3.
